led_matrix_scan: RTL and testbench



---
 rtl/led_matrix_scan_if.sv | 12 +
 rtl/led_matrix_scan.sv | 122 ++++++++++++
 tb/tb_led_matrix_scan.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/led_matrix_scan_if.sv
// Frame handshake between display_state (master) and led_matrix_scan (slave).
//   frame_data  : 64-bit frame, row r = frame_data[8r+7:8r], bit c = column c
//   frame_valid : frame_data is valid
//   frame_ready : scanner can take a frame; transfer on valid && ready
interface led_matrix_scan_if;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/led_matrix_scan.sv
// Row-scan driver for the 8x8 LED dot matrix. Double-buffers whole frames,
// drives one row per slot with a blanking gap at the start of each slot, and
// swaps to a newly accepted frame only on the last cycle of row 7.
//
// Ports:
//   clk         : system clock
//   rst         : synchronous reset, active-high
//   frame_if    : slave side of the frame handshake (data/valid/ready)
//   brightness  : 0..7 column duty level, honoured only with LED_BRIGHTNESS_EN
//   col_pin     : column drive, active-high
//   row_pin     : row select, active-low
//   frame_start : one-cycle pulse on the first drive cycle of row 0
//
// Optional feature macro: LED_BRIGHTNESS_EN (per-frame brightness duty).
module led_matrix_scan #(
  parameter int unsigned DWELL_CYC = 1250,
  parameter int unsigned BLANK_CYC = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  led_matrix_scan_if.slave         frame_if,
  input  logic [2:0]               brightness,
  output logic [7:0]               col_pin,
  output logic [7:0]               row_pin,
  output logic                     frame_start
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYC);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       row, row_nxt;
  logic [63:0]      active, pending;
  logic             pending_full;

  logic             slot_end_c;
  logic             frame_end_c;
  logic             accept_c;
  logic             drive_c;
  logic             col_en_c;
  logic [7:0]       row_byte_c;

  assign frame_if.frame_ready = ~pending_full;

  assign slot_end_c  = (cnt == CNT_W'(DWELL_CYC - 1));
  assign frame_end_c = slot_end_c && (row == 3'd7);
  assign accept_c    = frame_if.frame_valid && !pending_full;

  // Next scan position; outputs are computed from it so the registered pins
  // line up with the counter value held during the same cycle.
  always_comb begin
    cnt_nxt    = cnt + CNT_W'(1);
    row_nxt    = row;
    if (slot_end_c) begin
      cnt_nxt = '0;
      row_nxt = row + 3'd1;
    end
    drive_c    = (cnt_nxt >= CNT_W'(BLANK_CYC));
    row_byte_c = active[{row_nxt, 3'b000} +: 8];
  end

`ifdef LED_BRIGHTNESS_EN
  localparam int unsigned DRIVE_CYC = DWELL_CYC - BLANK_CYC;

  logic [2:0]  bright_q;
  logic [31:0] on_len_c;

  // Level is latched once per frame so the duty never changes mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      bright_q <= 3'd7;
    end else if (frame_end_c) begin
      bright_q <= brightness;
    end
  end

  always_comb begin
    on_len_c = ((32'(bright_q) + 32'd1) * 32'(DRIVE_CYC)) / 32'd8;
    col_en_c = (32'(cnt_nxt) < (32'(BLANK_CYC) + on_len_c));
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign col_en_c          = 1'b1;
`endif

  // Scan counters, frame buffers and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      row          <= 3'd0;
      active       <= 64'h0;
      pending      <= 64'h0;
      pending_full <= 1'b0;
      row_pin      <= 8'hFF;
      col_pin      <= 8'h00;
      frame_start  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      row <= row_nxt;

      // Accept and swap are mutually exclusive: accept needs pending empty,
      // swap needs it full.
      if (accept_c) begin
        pending      <= frame_if.frame_data;
        pending_full <= 1'b1;
      end else if (frame_end_c && pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end

      if (drive_c) begin
        row_pin <= ~(8'h01 << row_nxt);
        col_pin <= col_en_c ? row_byte_c : 8'h00;
      end else begin
        row_pin <= 8'hFF;
        col_pin <= 8'h00;
      end
      frame_start <= (cnt_nxt == CNT_W'(BLANK_CYC)) && (row_nxt == 3'd0);
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Scoreboard bench for led_matrix_scan with DWELL_CYC=20, BLANK_CYC=4.
// The driver pushes the expected pin state for each cycle from a reference
// model written in terms of elapsed cycles since reset; a negedge monitor pops
// and compares against the DUT pins.
module tb_led_matrix_scan;

  localparam int unsigned DW    = 20;
  localparam int unsigned BL    = 4;
  localparam int unsigned FRAME = 8 * DW;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
    logic       fs;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] brightness = 3'd7;
  logic [7:0] col_pin, row_pin;
  logic       frame_start;

  led_matrix_scan_if bus ();

  led_matrix_scan #(.DWELL_CYC(DW), .BLANK_CYC(BL)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_if    (bus),
    .brightness  (brightness),
    .col_pin     (col_pin),
    .row_pin     (row_pin),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state: cycles since reset, shown frame, pending frame.
  int unsigned m_t    = 0;
  logic [63:0] m_act  = 64'h0;
  logic [63:0] m_pend = 64'h0;
  bit          m_full = 1'b0;
  int unsigned m_bri  = 7;

  function automatic exp_t model_out();
    exp_t        e;
    int unsigned slot, r;
    slot  = m_t % DW;
    r     = (m_t / DW) % 8;
    e.rdy = !m_full;
    if (slot < BL) begin
      e.row = 8'hFF;
      e.col = 8'h00;
      e.fs  = 1'b0;
    end else begin
      e.row = ~(8'h01 << r);
      e.col = 8'(m_act >> (8 * r));
      e.fs  = (r == 0) && (slot == BL);
`ifdef LED_BRIGHTNESS_EN
      if ((slot - BL) >= ((m_bri + 1) * (DW - BL)) / 8) e.col = 8'h00;
`endif
    end
    return e;
  endfunction

  // One clock cycle: record expectation, apply inputs, advance the model.
  task automatic cycle(input bit r_i, input bit v_i, input logic [63:0] d_i,
                       input logic [2:0] b_i);
    bit last;
    @(posedge clk);
    #1;
    q.push_back(model_out());
    rst             = r_i;
    bus.frame_valid = v_i;
    bus.frame_data  = d_i;
    brightness      = b_i;
    if (r_i) begin
      m_t = 0; m_act = 64'h0; m_pend = 64'h0; m_full = 1'b0; m_bri = 7;
    end else begin
      last = ((m_t % FRAME) == FRAME - 1);
      if (last) m_bri = b_i;
      if (last && m_full) begin
        m_act  = m_pend;
        m_full = 1'b0;
      end else if (v_i && !m_full) begin
        m_pend = d_i;
        m_full = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a pin state every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("row_pin", row_pin, e.row);
      check("col_pin", col_pin, e.col);
      check("frame_start", {7'd0, frame_start}, {7'd0, e.fs});
      check("frame_ready", {7'd0, bus.frame_ready}, {7'd0, e.rdy});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit done;
    bus.frame_valid = 1'b0;
    bus.frame_data  = 64'h0;

    // Reset held for three edges, then the known frame at cycle 2 and an
    // all-ones frame offered continuously while pending is full.
    cycle(1'b1, 1'b0, 64'h0, 3'd7);
    cycle(1'b1, 1'b0, 64'h0, 3'd7);
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == 2)      cycle(1'b0, 1'b1, 64'h0123456789ABCDEF, 3'd7);
      else if (c > 2)  cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd7);
      else             cycle(1'b0, 1'b0, 64'h0, 3'd7);
    end

    // Random frames, offers and brightness levels.
    for (int c = 0; c < 6 * FRAME; c++) begin
      cycle(1'b0, ($urandom % 8) == 0, {$urandom, $urandom}, 3'($urandom_range(0, 7)));
    end

    // Reset at slot position 95 with a frame waiting in the pending buffer.
    done = 1'b0;
    for (int c = 0; c < 4 * FRAME && !done; c++) begin
      if ((m_t % FRAME) == 95 && m_full) begin
        cycle(1'b1, 1'b0, 64'h0, 3'd7);
        done = 1'b1;
      end else begin
        cycle(1'b0, !m_full, 64'hA5A5_5A5A_C3C3_3C3C, 3'd7);
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL mid_frame_reset: got no reset opportunity expected one within budget");
    end
    for (int c = 0; c < 2 * FRAME; c++) cycle(1'b0, 1'b0, 64'h0, 3'd7);

    // Brightness 3 with an all-ones frame.
    for (int c = 0; c < 4 * FRAME; c++) begin
      cycle(1'b0, !m_full, 64'hFFFF_FFFF_FFFF_FFFF, 3'd3);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
